rr_decoder_arbiter: RTL and testbench
=====================================

# rr_decoder_arbiter

Round-robin arbiter that shares one 8-way one-hot select (the 3-to-8 decoder output bus) among eight requesters. Each cycle it picks at most one requester, drives its one-hot grant on `S` and its binary index on `A`, and holds the grant until the requester releases or a hold timeout expires. It sits between the requesting units and the shared resource the decoded select lines enable.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles a single grant may be held (legal range 1..255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `E`  in  1  arbiter enable; 0 blocks new grants and ends any active grant.
- `req`  in  8  request vector; `req[i]`=1 means requester i wants the resource.
- `S`  out  8  one-hot grant; all zero when no grant is active.
- `A`  out  3  binary index of the granted requester; valid only while `gnt_valid`=1.
- `gnt_valid`  out  1  high while a grant is active (equals `|S`).
- `timeout`  out  1  one-cycle pulse when a grant is ended by `MAX_HOLD` expiry.

## Operation
- Registered outputs only; no combinational path from `req` or `E` to `S`, `A`, `gnt_valid` or `timeout`.
- Internal state: FSM {IDLE, GRANT, GAP}, 3-bit last-served pointer `ptr`, 8-bit hold counter `cnt`.
- Reset (`rst`=1 at an edge, regardless of state): FSM=IDLE, `S`=0, `A`=0, `gnt_valid`=0, `timeout`=0, `cnt`=0, `ptr`=7 (requester 0 has top priority after reset).
- IDLE: if `E`=1 and `req`≠0, select the first set `req[i]` scanning i = `ptr`+1, `ptr`+2, … modulo 8. Register `A`=i, `S`=1<<i, `gnt_valid`=1, `cnt`=1, go GRANT. Otherwise stay in IDLE with `S`=0.
- GRANT: the grant is held. End it at the next edge if any of the following holds (evaluated on current inputs):
  - `req[A]`=0: normal release.
  - `E`=0: forced release, no `timeout`.
  - `cnt`=`MAX_HOLD` with `req[A]`=1 and `E`=1: `timeout`=1 for exactly the next cycle.
- Ending a grant: `S`=0, `gnt_valid`=0, `ptr`=`A`, `cnt`=0, go GAP. `A` keeps its last value.
- If the grant is not ended: increment `cnt` by 1. `cnt` saturates and never wraps past `MAX_HOLD`.
- GAP: one mandatory dead cycle with `S`=0 (break-before-make between requesters), then IDLE. Requests present during GAP are evaluated in IDLE.
- Requests from other requesters never preempt an active grant.
- Wrap-around: with `ptr`=7 the scan starts at 0. With `ptr`=i and only `req[i]` set, i is granted again, after GAP+IDLE.
- `MAX_HOLD`=1: every grant lasts exactly one cycle. `timeout` pulses whenever the requester is still requesting at the end of that cycle.

## Timing
- Grant latency: `req` and `E` sampled at edge N in IDLE produce `S` asserted in the cycle after edge N (1 cycle).
- Release latency: `req[A]` low at edge N produces `S`=0 after edge N. The earliest next grant appears after edge N+2 (GAP at N+1, IDLE decision at N+2, `S` valid after N+2).
- Back-to-back handover between two requesters: grant, at least 1 cycle of GAP with `S`=0, 1 IDLE decision cycle, new grant. Minimum spacing between the end of one grant and the next is 2 cycles.
- Maximum grant length is `MAX_HOLD` cycles of `S` high. `timeout` is asserted in the first GAP cycle.
- `S` is always zero or one-hot. When `gnt_valid`=1, `S` equals 1<<`A`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=8'hFF, `E`=1 -> `S`=0, `A`=0, `gnt_valid`=0, `timeout`=0. After release, the first grant is `S`=8'b00000001, `A`=0.
- Round-robin fairness: `req`=8'hFF held, `E`=1, each grant ended by dropping that requester's bit for 1 cycle -> grant order 0,1,2,…,7,0, with `S`=0 for 2 cycles between grants.
- Timeout: `MAX_HOLD`=4, `req`=8'b00001000 held constant -> `S`=8'b00001000 for exactly 4 cycles, then `timeout`=1 for 1 cycle with `S`=0, then the grant to 3 is reissued.
- Enable: `E`=0 with `req`=8'hA5 -> `S` stays 0. Drop `E` mid-grant -> `S`=0 after the next edge, `timeout`=0, no new grant while `E`=0.
- Wrap and skip: after a grant to 6, `req`=8'b00000101 -> next grant `A`=0, then `A`=2. A later `req`=8'b10000000 after serving 7 -> 7 regranted after GAP.
- Reset mid-grant: assert `rst` for 1 cycle while `S`=8'b00100000 -> `S`=0 after that edge. The next grant with `req`=8'b00100001 goes to 0 (`ptr` reset to 7).

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// -----------------------------------------------------------------------------
// rr_decoder_arbiter
//
// Round-robin arbiter driving one shared 8-way one-hot select bus. At most one
// requester holds the bus at a time. A grant lasts until the requester drops
// its request, the arbiter is disabled, or MAX_HOLD cycles elapse. Every grant
// is followed by one dead cycle (GAP) and one decision cycle (IDLE), so two
// different requesters never see their select lines overlap.
//
// Parameters:
//   MAX_HOLD   maximum consecutive cycles one grant may be held (1..255)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   E          enable; low blocks new grants and ends an active grant
//   req[7:0]   request vector, bit i set means requester i wants the bus
//   S[7:0]     registered one-hot grant, zero when no grant is active
//   A[2:0]     registered binary index of the granted requester
//   gnt_valid  registered, high while a grant is active
//   timeout    registered one-cycle pulse when a grant hits MAX_HOLD
// -----------------------------------------------------------------------------
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] req,
    output logic [7:0] S,
    output logic [2:0] A,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [1:0] state_q, state_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] s_q,     s_d;
    logic [2:0] a_q,     a_d;
    logic       gv_q,    gv_d;
    logic       to_q,    to_d;

    // Requests rotated so that position 0 is the requester just after the
    // last-served one; position 7 is the last-served requester itself.
    logic [2:0] rot_idx [8];
    logic [7:0] req_rot;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_idx[gi] = ptr_q + 3'(gi + 1);
            assign req_rot[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Lowest rotated position wins: scanning downward lets it overwrite.
    logic [2:0] pick_idx;
    always_comb begin
        pick_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_idx = rot_idx[k];
            end
        end
    end

    logic at_limit;
    logic end_grant;
    assign at_limit  = (cnt_q == HOLD_LIMIT);
    assign end_grant = !req[a_q] || !E || at_limit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        a_d     = a_q;
        gv_d    = gv_q;
        to_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_d  = 8'h00;
                gv_d = 1'b0;
                if (E && (req != 8'h00)) begin
                    a_d     = pick_idx;
                    s_d     = 8'h01 << pick_idx;
                    gv_d    = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (end_grant) begin
                    s_d     = 8'h00;
                    gv_d    = 1'b0;
                    ptr_d   = a_q;
                    cnt_d   = 8'd0;
                    state_d = ST_GAP;
                    // Only a limit hit on a still-wanted, still-enabled grant
                    // counts as a timeout; releases and disables do not.
                    to_d    = req[a_q] && E && at_limit;
                end else if (!at_limit) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                s_d     = 8'h00;
                gv_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                s_d     = 8'h00;
                gv_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 3'd7;
            cnt_q   <= 8'd0;
            s_q     <= 8'h00;
            a_q     <= 3'd0;
            gv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            a_q     <= a_d;
            gv_q    <= gv_d;
            to_q    <= to_d;
        end
    end

    assign S         = s_q;
    assign A         = a_q;
    assign gnt_valid = gv_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_decoder_arbiter
//
// Drives directed sequences (reset, fairness, timeout, enable, wrap, reset
// mid-grant) followed by random traffic. A behavioural model tracks who owns
// the bus, for how many cycles, and who was served last; a compare process
// checks every DUT output against it on each negative clock edge. Directed
// sections add literal expectations that pin the model itself.
// -----------------------------------------------------------------------------
module tb_rr_decoder_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       E   = 1'b1;
    logic [7:0] req = 8'hFF;
    logic [7:0] S;
    logic [2:0] A;
    logic       gnt_valid;
    logic       timeout;

    rr_decoder_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .E         (E),
        .req       (req),
        .S         (S),
        .A         (A),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int       owner;  // requester holding the bus, -1 when none
        int       last;   // last requester whose grant ended
        int       held;   // cycles the current owner has had the bus
        bit       gap;    // currently in the dead cycle after a grant
        bit       to;     // timeout pulse
        int       a;      // last granted index
    } mstate_t;

    function automatic mstate_t step(mstate_t s, logic r, logic en, logic [7:0] q);
        mstate_t n = s;
        n.to = 1'b0;
        if (r) begin
            n.owner = -1; n.last = 7; n.held = 0; n.gap = 1'b0; n.a = 0;
        end else if (s.owner >= 0) begin
            if (!q[s.owner] || !en || s.held == HOLD) begin
                n.to    = q[s.owner] && en && (s.held == HOLD);
                n.last  = s.owner;
                n.owner = -1;
                n.held  = 0;
                n.gap   = 1'b1;
            end else begin
                n.held = s.held + 1;
            end
        end else if (s.gap) begin
            n.gap = 1'b0;
        end else if (en && q != 8'h00) begin
            for (int k = 8; k >= 1; k--) begin
                if (q[(s.last + k) % 8]) n.owner = (s.last + k) % 8;
            end
            n.a    = n.owner;
            n.held = 1;
        end
        return n;
    endfunction

    mstate_t m;
    bit      chk_en = 1'b0;

    always @(posedge clk) begin
        m      <= step(m, rst, E, req);
        chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_S", S, (m.owner >= 0) ? 32'(8'h01 << m.owner) : 32'h0);
            chk("model_gnt_valid", gnt_valid, (m.owner >= 0) ? 1 : 0);
            chk("model_timeout", timeout, m.to);
            if (m.owner >= 0) chk("model_A", A, m.a);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all requests active
        rst = 1'b1; req = 8'hFF; E = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_S", S, 0);
            chk("rst_A", A, 0);
            chk("rst_gv", gnt_valid, 0);
            chk("rst_to", timeout, 0);
        end
        rst = 1'b0;
        cyc();
        chk("first_S", S, 8'h01);
        chk("first_A", A, 0);

        // Fairness: drop the granted bit for one cycle each time
        for (int k = 1; k <= 8; k++) begin
            req = 8'hFF & ~(8'h01 << A);
            cyc();
            req = 8'hFF;
            chk("rr_gap1_S", S, 0);
            cyc();
            chk("rr_gap2_S", S, 0);
            cyc();
            chk("rr_order_S", S, 32'(8'h01 << (k % 8)));
        end

        // Enable drop mid-grant, then idle with E=0
        E = 1'b0; req = 8'hA5;
        cyc();
        chk("en_drop_S", S, 0);
        chk("en_drop_to", timeout, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("en_off_S", S, 0);
        end

        // Timeout with a single persistent requester
        req = 8'h08; E = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            cyc();
            chk("hold_S", S, 8'h08);
        end
        cyc();
        chk("to_S", S, 0);
        chk("to_pulse", timeout, 1);
        cyc();
        chk("to_after", timeout, 0);
        cyc();
        chk("regrant_S", S, 8'h08);

        // Wrap and skip
        req = 8'h00;
        cyc(); cyc();
        req = 8'h40;
        cyc();
        chk("grant6_A", A, 6);
        req = 8'h05;
        cyc(); cyc(); cyc();
        chk("wrap_A0", A, 0);
        req = 8'h04;
        cyc();
        req = 8'h05;
        cyc(); cyc();
        chk("skip_A2", A, 2);
        req = 8'h80;
        cyc(); cyc(); cyc();
        chk("grant7_A", A, 7);
        req = 8'h00;
        cyc();
        req = 8'h80;
        cyc(); cyc();
        chk("regrant7_A", A, 7);
        chk("regrant7_S", S, 8'h80);

        // Reset mid-grant
        req = 8'h20;
        cyc(); cyc(); cyc();
        chk("grant5_S", S, 8'h20);
        rst = 1'b1;
        cyc();
        chk("midrst_S", S, 0);
        rst = 1'b0; req = 8'h21;
        cyc();
        chk("postrst_S", S, 8'h01);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) req = 8'($urandom & $urandom);
            E   = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
